// File: rtl/memory_ctrl.sv
// Single-port word array behind a valid/ready request port, with a fill sweep
// after reset or clear and a 1- or 2-cycle registered read path.
module memory_ctrl #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 2**ADDR_W,
    parameter logic [DATA_W-1:0] FILL_VAL = '1,
    parameter int                RD_LAT   = 1
) (
    input  logic                clk,
    input  logic                reset1,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                rd_wr1,
    input  logic [ADDR_W-1:0]   addr1,
    input  logic [DATA_W-1:0]   wr_data1,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                clear,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rd_data1,
    output logic                rsp_err,
    output logic                init_done
);

    localparam int                BYTES     = DATA_W / 8;
    localparam logic [0:0]        ST_INIT   = 1'b0;
    localparam logic [0:0]        ST_RUN    = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

    logic [0:0]        state;
    logic [ADDR_W-1:0] sweep_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_range;
    logic              req_acc;
    logic              rd_acc;
    logic              wr_acc;
    logic [DATA_W-1:0] rd_sample;

    logic              vld_p0;
    logic              err_p0;
    logic [DATA_W-1:0] data_p0;

    // clear wins over a same-cycle request by masking ready
    assign req_ready = (state == ST_RUN) && !clear;
    assign init_done = (state == ST_RUN);
    assign in_range  = {1'b0, addr1} < DEPTH_X;
    assign req_acc   = req_valid && req_ready;
    assign rd_acc    = req_acc && rd_wr1;
    assign wr_acc    = req_acc && !rd_wr1 && in_range;
    assign rd_sample = in_range ? mem[addr1] : FILL_VAL;

    always_ff @(posedge clk or posedge reset1) begin
        if (reset1) begin
            state     <= ST_INIT;
            sweep_cnt <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (sweep_cnt == LAST_ADDR) begin
                        state     <= ST_RUN;
                        sweep_cnt <= '0;
                    end else begin
                        sweep_cnt <= sweep_cnt + 1'b1;
                    end
                end
                default: begin
                    if (clear) begin
                        state     <= ST_INIT;
                        sweep_cnt <= '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[sweep_cnt] <= FILL_VAL;
        end else if (wr_acc) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wr_be[b]) begin
                    mem[addr1][8*b +: 8] <= wr_data1[8*b +: 8];
                end
            end
        end
    end

    // Stage p0: array sampled on the accept edge, before any later write lands
    always_ff @(posedge clk or posedge reset1) begin
        if (reset1) begin
            vld_p0  <= 1'b0;
            err_p0  <= 1'b0;
            data_p0 <= '0;
        end else begin
            vld_p0 <= rd_acc;
            if (rd_acc) begin
                err_p0  <= !in_range;
                data_p0 <= rd_sample;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              vld_p1;
            logic              err_p1;
            logic [DATA_W-1:0] data_p1;

            // Stage p1: extra output register
            always_ff @(posedge clk or posedge reset1) begin
                if (reset1) begin
                    vld_p1  <= 1'b0;
                    err_p1  <= 1'b0;
                    data_p1 <= '0;
                end else begin
                    vld_p1 <= vld_p0;
                    if (vld_p0) begin
                        err_p1  <= err_p0;
                        data_p1 <= data_p0;
                    end
                end
            end

            assign rsp_valid = vld_p1;
            assign rsp_err   = err_p1;
            assign rd_data1  = data_p1;
        end else begin : g_lat1
            assign rsp_valid = vld_p0;
            assign rsp_err   = err_p0;
            assign rd_data1  = data_p0;
        end
    endgenerate

endmodule

// File: doc/memory_ctrl.md
MEMORY_CTRL -- requirements
Module: memory_ctrl

Parameters
REQ-001 DATA_W, 8, data width in bits; SHALL be a multiple of 8.
REQ-002 ADDR_W, 8, address width in bits.
REQ-003 DEPTH, 2**ADDR_W, number of words implemented; SHALL be <= 2**ADDR_W.
REQ-004 FILL_VAL, all ones, value every word holds after init or clear.
REQ-005 RD_LAT, 1, read latency in cycles; legal values 1 or 2.

Interface
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 reset1  in  1  asynchronous, active-high reset.
REQ-008 req_valid  in  1  request present.
REQ-009 req_ready  out  1  controller accepts a request this cycle.
REQ-010 rd_wr1  in  1  1 = read, 0 = write.
REQ-011 addr1  in  ADDR_W  word address.
REQ-012 wr_data1  in  DATA_W  write data.
REQ-013 wr_be  in  DATA_W/8  byte enables for writes; bit i covers byte i.
REQ-014 clear  in  1  single-cycle pulse; refill whole array with FILL_VAL.
REQ-015 rsp_valid  out  1  one-cycle pulse, read data valid.
REQ-016 rd_data1  out  DATA_W  read data, qualified by rsp_valid.
REQ-017 rsp_err  out  1  out-of-range read flag, qualified by rsp_valid.
REQ-018 init_done  out  1  high when the array holds valid contents and the controller is in RUN.

Function
REQ-019 FSM SHALL have exactly two states: INIT (fill sweep) and RUN.
REQ-020 INIT SHALL write FILL_VAL to addresses 0..DEPTH-1, one per cycle in ascending order, using an internal counter.
REQ-021 INIT -> RUN SHALL occur on the cycle after the write to DEPTH-1; req_ready and init_done SHALL rise that cycle.
REQ-022 In INIT, req_ready SHALL be 0 and req_valid SHALL be ignored.
REQ-023 In RUN, req_ready SHALL equal NOT clear; a request SHALL be accepted when req_valid and req_ready are both 1.
REQ-024 Accepted write: bytes with wr_be=1 SHALL be updated and bytes with wr_be=0 SHALL be unchanged; wr_be=0 in every bit is a legal no-op.
REQ-025 Accepted read: the array SHALL be sampled in the accept cycle, and rsp_valid SHALL pulse exactly RD_LAT cycles later with that data.
REQ-026 Back-to-back reads SHALL be accepted every cycle, giving one rsp_valid per read in request order.
REQ-027 A write accepted the cycle after a read to the same address SHALL NOT affect that read's data; the read returns the old value.
REQ-028 Out-of-range addresses (addr1 >= DEPTH): writes SHALL be dropped, and reads SHALL return FILL_VAL with rsp_err=1; in-range reads SHALL return rsp_err=0.
REQ-029 clear in RUN SHALL enter INIT on the next cycle and restart the sweep at address 0; init_done SHALL fall in that same cycle.
REQ-030 clear in INIT SHALL be ignored; the sweep continues uninterrupted.
REQ-031 Reads accepted before clear SHALL complete normally with pre-clear data.
REQ-032 clear has priority over req_valid in the same cycle; that request SHALL NOT be accepted.
REQ-033 rsp_valid SHALL be 0 in every cycle that has no matching read.

Reset
REQ-034 Asserting reset1 SHALL immediately, without waiting for a clock edge, force: req_ready=0, init_done=0, rsp_valid=0, rsp_err=0, rd_data1=0, read pipeline flushed, state=INIT, sweep counter=0.
REQ-035 Array contents are not reset directly; after reset1 deasserts, the sweep starts on the first rising edge.
REQ-036 Reset asserted mid-read SHALL discard the pending response; no rsp_valid SHALL appear after release.

Verification
REQ-037 Defaults: release reset1 -> req_ready=0 for exactly 256 cycles, then 1; read 0x10 -> rd_data1=0xFF, rsp_err=0, one cycle after accept.
REQ-038 Defaults: write 0x3C to 0x10, then read 0x10 next cycle -> 0x3C; write 0x55 to 0x10 the cycle after a read of 0x10 -> that read returns 0x3C.
REQ-039 DATA_W=32, RD_LAT=2: write 0x11223344 be=0xF, then 0xAABBCCDD be=0x5 to 0x04, then read 0x04 -> 0x11BB33DD after 2 cycles.
REQ-040 DEPTH=200: write 0x00 to 0xC8, then read 0xC8 -> 0xFF with rsp_err=1; read 0xC7 -> rsp_err=0.
REQ-041 Defaults: write 0x12 to 0x05, read 0x05, clear on the next cycle -> read returns 0x12, req_ready low for 256 cycles, then read 0x05 -> 0xFF.
REQ-042 Defaults: assert reset1 mid-cycle on the cycle after a read is accepted -> outputs zero before the next edge, no rsp_valid, and the sweep restarts after release.
